// File: rtl/seq_booth_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_booth_mult
// Purpose  : Sequential radix-4 Booth multiplier with signed/unsigned operands
//            and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module seq_booth_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result_out
);

    localparam int ITER  = WIDTH / 2 + 1;
    localparam int EXT_W = WIDTH + 2;
    localparam int SHIFT = 2 * ITER;
    // Partial products enter at the top so the right shifts never drop set bits.
    localparam int ACC_W = EXT_W + 1 + SHIFT;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [EXT_W-1:0]         mcand_q;
    logic [EXT_W-1:0]         mult_q;
    logic                     mult_prev_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [2*WIDTH-1:0]       result_q;

    logic [EXT_W-1:0]         mcand_ext_d;
    logic [EXT_W-1:0]         mult_ext_d;
    logic [2:0]               triplet;
    logic signed [ACC_W-1:0]  mcand_wide;
    logic signed [ACC_W-1:0]  pp;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_d;

    always_comb begin
        mcand_ext_d = {{2{is_signed & ina[WIDTH-1]}}, ina};
        mult_ext_d  = {{2{is_signed & inb[WIDTH-1]}}, inb};
        triplet     = {mult_q[1:0], mult_prev_q};
        mcand_wide  = {{(ACC_W-EXT_W){mcand_q[EXT_W-1]}}, mcand_q};
        case (triplet)
            3'b001, 3'b010: pp = mcand_wide;
            3'b011:         pp = mcand_wide <<< 1;
            3'b100:         pp = -(mcand_wide <<< 1);
            3'b101, 3'b110: pp = -mcand_wide;
            default:        pp = '0;
        endcase
        sum   = acc_q + (pp <<< SHIFT);
        acc_d = sum >>> 2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mult_q      <= '0;
            mult_prev_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q     <= mcand_ext_d;
                        mult_q      <= mult_ext_d;
                        mult_prev_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= ITER_CNT;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q       <= acc_d;
                    mult_q      <= {2'b00, mult_q[EXT_W-1:2]};
                    mult_prev_q <= mult_q[1];
                    cnt_q       <= cnt_q - LAST_CNT;
                    if (cnt_q == LAST_CNT) begin
                        result_q <= acc_d[2*WIDTH-1:0];
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign result_out = result_q;

endmodule
`default_nettype wire
